// File: rtl/hstx_serializer_pkg.sv
// Shared HS transmit definitions: serializer state encoding, default byte width
// and the levels the HS pair rests at when the driver is off.
package hstx_serializer_pkg;

    localparam int HSTX_DATA_W = 8;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_SHIFT = 2'd1,
        SER_TRAIL = 2'd2
    } ser_state_e;

    localparam logic HS_DP_IDLE = 1'b0;
    localparam logic HS_DN_IDLE = 1'b1;

endpackage

// File: rtl/hstx_serializer.sv
// HS byte-to-bit serializer: shifts hstx_fsm bytes out on HS_Dp/HS_Dn one bit per
// clock with seamless back-to-back bytes and an optional inverted-last-bit trail.
module hstx_serializer
    import hstx_serializer_pkg::*;
#(
    parameter int DATA_W     = HSTX_DATA_W,
    parameter int LSB_FIRST  = 1,
    parameter int TRAIL_BITS = 0
) (
    input  logic              TxDDRClkHS,
    input  logic              TxRst,
    input  logic              serial_en,
    input  logic [DATA_W-1:0] HSFSM_Bytes,
    output logic              HS_Dp,
    output logic              HS_Dn,
    output logic              hs_drive_en,
    output logic              byte_done,
    output logic              ser_busy
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TW = (TRAIL_BITS > 1) ? $clog2(TRAIL_BITS) : 1;
    localparam logic [CW-1:0] BIT_LAST   = CW'(DATA_W - 1);
    localparam logic [TW-1:0] TRAIL_LAST = TW'((TRAIL_BITS > 0) ? TRAIL_BITS - 1 : 0);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]     trail_cnt_q, trail_cnt_d;
    logic              last_bit_q, last_bit_d;
    logic              hs_dp_q, hs_dp_d;
    logic              hs_dn_q;
    logic              byte_done_q, byte_done_d;
    logic              busy_q, busy_d;
    logic              load;
    logic [CW-1:0]     idx_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        trail_cnt_d = trail_cnt_q;
        last_bit_d  = last_bit_q;
        load        = 1'b0;

        case (state_q)
            SER_IDLE: begin
                if (serial_en) load = 1'b1;
            end
            SER_SHIFT: begin
                // serial_en only matters at the byte boundary; a byte is never truncated
                if (bit_cnt_q == BIT_LAST) begin
                    if (serial_en) begin
                        load = 1'b1;
                    end else if (TRAIL_BITS > 0) begin
                        state_d     = SER_TRAIL;
                        trail_cnt_d = '0;
                        last_bit_d  = hs_dp_q;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            SER_TRAIL: begin
                if (trail_cnt_q == TRAIL_LAST) begin
                    state_d     = SER_IDLE;
                    trail_cnt_d = '0;
                end else begin
                    trail_cnt_d = trail_cnt_q + 1'b1;
                end
            end
            default: state_d = SER_IDLE;
        endcase

        if (load) begin
            state_d   = SER_SHIFT;
            shreg_d   = HSFSM_Bytes;
            bit_cnt_d = '0;
        end

        // Outputs are computed from next state so they land registered in the same cycle
        idx_d = (LSB_FIRST != 0) ? bit_cnt_d : (BIT_LAST - bit_cnt_d);
        case (state_d)
            SER_SHIFT: hs_dp_d = shreg_d[idx_d];
            SER_TRAIL: hs_dp_d = ~last_bit_d;
            default:   hs_dp_d = HS_DP_IDLE;
        endcase
        byte_done_d = (state_d == SER_SHIFT) && (bit_cnt_d == BIT_LAST);
        busy_d      = (state_d != SER_IDLE);
    end

    always_ff @(posedge TxDDRClkHS) begin
        if (TxRst) begin
            state_q     <= SER_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            trail_cnt_q <= '0;
            last_bit_q  <= 1'b0;
            hs_dp_q     <= HS_DP_IDLE;
            hs_dn_q     <= HS_DN_IDLE;
            byte_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            trail_cnt_q <= trail_cnt_d;
            last_bit_q  <= last_bit_d;
            hs_dp_q     <= hs_dp_d;
            hs_dn_q     <= ~hs_dp_d;
            byte_done_q <= byte_done_d;
            busy_q      <= busy_d;
        end
    end

    assign HS_Dp       = hs_dp_q;
    assign HS_Dn       = hs_dn_q;
    assign hs_drive_en = busy_q;
    assign byte_done   = byte_done_q;
    assign ser_busy    = busy_q;

endmodule

// File: doc/hstx_serializer.md
Name: hstx_serializer

Overview:
- Downstream neighbour of hstx_fsm in the HS transmit path.
- Takes the byte stream HSFSM_Bytes, qualified by serial_en, and shifts it out one bit per TxDDRClkHS cycle, LSB first, as the complementary pair HS_Dp/HS_Dn.
- Drives the HS line-driver enable.
- Optionally appends a HS-TRAIL segment, holding the inverse of the last bit, when the stream ends.

Parameters:
- DATA_W, 8, byte width; also the number of bits per byte period.
- LSB_FIRST, 1: 1 = bit 0 is transmitted first; 0 = MSB first.
- TRAIL_BITS, 0: number of cycles of inverted-last-bit trail after the final byte. 0 disables the trail, because hstx_fsm supplies trail bytes itself.

Ports:
- TxDDRClkHS  in  1  HS serial clock; all logic is on the rising edge.
- TxRst  in  1  reset, synchronous, active-high.
- serial_en  in  1  from hstx_fsm; 1 = HSFSM_Bytes holds a valid byte to send.
- HSFSM_Bytes  in  DATA_W  byte from hstx_fsm; held stable for DATA_W cycles.
- HS_Dp  out  1  serial data, true polarity.
- HS_Dn  out  1  serial data, complement (always ~HS_Dp).
- hs_drive_en  out  1  HS driver enable.
- byte_done  out  1  one-cycle pulse in the cycle the last bit of a byte is on HS_Dp.
- ser_busy  out  1  1 in SHIFT or TRAIL.

Behaviour:
- Interface (already decided): one clock, TxDDRClkHS; reset TxRst is synchronous and active-high.
- Reset values (next edge with TxRst=1, including mid-byte): state=IDLE, shift reg=0, bit_cnt=0, trail_cnt=0, HS_Dp=0, HS_Dn=1, hs_drive_en=0, byte_done=0, ser_busy=0. Any partially sent byte is discarded.
- All outputs are registered.
- IDLE:
  - hs_drive_en=0, HS_Dp=0, HS_Dn=1.
  - If serial_en=1 at an edge: capture HSFSM_Bytes and go to SHIFT with bit_cnt=0.
  - The first bit appears on HS_Dp in the cycle after serial_en is sampled high (latency 1). hs_drive_en rises in that same cycle.
- SHIFT:
  - Each cycle HS_Dp = current bit (bit[bit_cnt] if LSB_FIRST, else bit[DATA_W-1-bit_cnt]); bit_cnt increments.
  - When bit_cnt=DATA_W-1, byte_done=1 for that cycle, and serial_en is sampled at that edge:
    - serial_en=1: capture HSFSM_Bytes, bit_cnt wraps to 0, stay in SHIFT. No gap bit; back-to-back bytes are seamless.
    - serial_en=0 and TRAIL_BITS>0: go to TRAIL and latch last_bit.
    - serial_en=0 and TRAIL_BITS=0: go to IDLE.
- serial_en is ignored mid-byte. A deassertion before the byte boundary does not truncate the byte; the full DATA_W bits are always sent.
- TRAIL:
  - HS_Dp = ~last_bit, hs_drive_en=1, for exactly TRAIL_BITS cycles, then IDLE.
  - serial_en=1 during TRAIL is ignored; a new burst starts only from IDLE.
- Invariants:
  - HS_Dn = ~HS_Dp in every state, including reset.
  - ser_busy = (state != IDLE), registered together with the state.
  - hs_drive_en = ser_busy.
- Widths: bit_cnt is $clog2(DATA_W) bits and wraps modulo DATA_W. trail_cnt is sized for TRAIL_BITS (minimum 1 bit).

Decomposition:
- Shared hstx package:
  - state encodings: SER_IDLE=2'd0, SER_SHIFT=2'd1, SER_TRAIL=2'd2;
  - DATA_W default;
  - the line-idle constants HS_DP_IDLE=0 and HS_DN_IDLE=1.
- Single module; no sub-module. The shift register and counters are small enough to stay inline.

Test Plan:
1. Reset then idle: TxRst=1 for 10 cycles, serial_en=0 for 10 cycles -> HS_Dp=0, HS_Dn=1, hs_drive_en=0, byte_done=0 throughout.
2. Single byte: serial_en=1 with 0xA5 held 8 cycles, then serial_en=0 -> HS_Dp = 1,0,1,0,0,1,0,1 starting 1 cycle after serial_en is sampled; byte_done on the 8th bit; hs_drive_en high for exactly 8 cycles; HS_Dn always the complement.
3. Back-to-back bytes: bytes 0xA5, 0x3C, 0x7E, 0x99, 8 cycles each, serial_en held high -> 32 contiguous bits with no gap: 10100101 00111100 01111110 10011001 (LSB first per byte); 4 byte_done pulses spaced 8 cycles apart.
4. Early deassert: serial_en drops 3 cycles into byte 0x0F -> all 8 bits 1,1,1,1,0,0,0,0 are still sent, then IDLE.
5. Trail: TRAIL_BITS=4, byte 0x80 with LSB_FIRST=1, so the last bit is 1 -> after the 8 data bits HS_Dp=0 for 4 cycles with hs_drive_en=1, then IDLE values.
6. Reset mid-byte: TxRst=1 asserted at bit 4 of 0xFF -> at the next edge HS_Dp=0, HS_Dn=1, hs_drive_en=0, ser_busy=0. After release with serial_en=1 and 0x01, transmission restarts cleanly with bit 0 = 1.
